tqv_harness_sequencer: RTL and testbench

Sequencer and arbiter that shares one TinyQV peripheral-harness command port between two requesters. Each requester issues register read or write transactions. The block grants one requester round-robin and drives the harness command/data lines through an address phase, a data or read phase and an acknowledge wait. It returns read data, or a timeout flag, through a single response channel. It sits between test or control logic and the cmd/wdata → data_out/data_ready interface of the compare-test top.

---
 rtl/tqv_harness_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tqv_harness_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_harness_sequencer.sv
// Round-robin sequencer sharing one TinyQV harness command port between two requesters.
// Each transaction runs ADDR -> WDATA/READ -> WAIT -> RESP and returns data or a timeout flag.
module tqv_harness_sequencer #(
  parameter int         TIMEOUT   = 255,
  parameter logic [2:0] CMD_IDLE  = 3'd0,
  parameter logic [2:0] CMD_ADDR  = 3'd1,
  parameter logic [2:0] CMD_WDATA = 3'd2,
  parameter logic [2:0] CMD_READ  = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [5:0]  req0_addr,
  input  logic [12:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [5:0]  req1_addr,
  input  logic [12:0] req1_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [12:0] rsp_data,
  output logic        rsp_timeout,
  output logic [2:0]  cmd_out,
  output logic [12:0] wdata_out,
  input  logic [12:0] data_in,
  input  logic        data_ready_in,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_READ  = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          last_grant_r;
  logic          grant_s;
  logic          accept_s;
  logic          sel_write_s;
  logic [5:0]    sel_addr_s;
  logic [12:0]   sel_wdata_s;
  logic          lat_write_r;
  logic          lat_id_r;
  logic [12:0]   lat_wdata_r;
  logic [CW-1:0] cnt_r;
  logic          wait_timeout_s;
  logic [2:0]    cmd_next_s;
  logic [12:0]   wdata_next_s;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s    = (state_r == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept_s && !grant_s;
  assign req1_ready  = accept_s && grant_s;
  assign sel_write_s = grant_s ? req1_write : req0_write;
  assign sel_addr_s  = grant_s ? req1_addr  : req0_addr;
  assign sel_wdata_s = grant_s ? req1_wdata : req0_wdata;
  assign busy        = (state_r != S_IDLE);

  // Limit is hit on the TIMEOUT-th WAIT cycle that still sees no acknowledge.
  assign wait_timeout_s = !data_ready_in && (cnt_r == CW'(TIMEOUT - 1));

  // Next-state decision plus the harness lines that the decided state will present.
  always_comb begin
    state_next_s = state_r;
    cmd_next_s   = CMD_IDLE;
    wdata_next_s = 13'd0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_next_s = S_ADDR;
        else          state_next_s = S_IDLE;
      end
      S_ADDR:  state_next_s = lat_write_r ? S_WDATA : S_READ;
      S_WDATA: state_next_s = S_WAIT;
      S_READ:  state_next_s = S_WAIT;
      S_WAIT: begin
        if (data_ready_in || wait_timeout_s) state_next_s = S_RESP;
        else                                 state_next_s = S_WAIT;
      end
      S_RESP: begin
        if (rsp_ready) state_next_s = S_IDLE;
        else           state_next_s = S_RESP;
      end
      default: state_next_s = S_IDLE;
    endcase
    case (state_next_s)
      S_ADDR: begin
        cmd_next_s   = CMD_ADDR;
        wdata_next_s = {6'd0, sel_write_s, sel_addr_s};
      end
      S_WDATA: begin
        cmd_next_s   = CMD_WDATA;
        wdata_next_s = lat_wdata_r;
      end
      S_READ: begin
        cmd_next_s   = CMD_READ;
        wdata_next_s = 13'd0;
      end
      default: begin
        cmd_next_s   = CMD_IDLE;
        wdata_next_s = 13'd0;
      end
    endcase
  end

  // State, harness lines, transaction latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cmd_out      <= CMD_IDLE;
      wdata_out    <= 13'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= 13'd0;
      rsp_timeout  <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= '0;
      lat_write_r  <= 1'b0;
      lat_id_r     <= 1'b0;
      lat_wdata_r  <= 13'd0;
    end else begin
      state_r   <= state_next_s;
      cmd_out   <= cmd_next_s;
      wdata_out <= wdata_next_s;
      rsp_valid <= (state_next_s == S_RESP);
      if (accept_s) begin
        lat_write_r  <= sel_write_s;
        lat_id_r     <= grant_s;
        lat_wdata_r  <= sel_wdata_s;
        last_grant_r <= grant_s;
      end
      if (state_r == S_WAIT) begin
        if (data_ready_in) begin
          rsp_id      <= lat_id_r;
          rsp_data    <= lat_write_r ? 13'd0 : data_in;
          rsp_timeout <= 1'b0;
        end else if (wait_timeout_s) begin
          rsp_id      <= lat_id_r;
          rsp_data    <= 13'd0;
          rsp_timeout <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tqv_harness_sequencer.sv
// Randomized scoreboard bench: a reference model predicts grants, harness commands
// (with cycle timing) and responses; a negedge monitor compares the DUT against it.
module tb_tqv_harness_sequencer;
  localparam int TO   = 8;
  localparam int NPER = 30;

  typedef struct {
    logic [2:0]  cmd;
    logic [12:0] data;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic        id;
    logic [12:0] data;
    logic        to;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rv = 2'b00;
  logic [1:0]  rw = 2'b00;
  logic [5:0]  ra [2];
  logic [12:0] rd [2];
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_timeout, busy;
  logic        rsp_ready = 1'b0;
  logic [12:0] rsp_data, wdata_out;
  logic [2:0]  cmd_out;
  logic [12:0] data_in = 13'd0;
  logic        data_ready_in = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   n_issued = 0;
  bit   last_m = 1'b1;
  bit   outst = 1'b0;
  bit   rsp_seen = 1'b0;
  bit   auto_resp = 1'b1;
  cmd_t       exp_cmd[$];
  rsp_t       exp_rsp[$];
  logic [1:0] exp_txn[$];  // {write, id} per accepted transaction

  tqv_harness_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_write(rw[0]),
    .req0_addr(ra[0]), .req0_wdata(rd[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_write(rw[1]),
    .req1_addr(ra[1]), .req1_wdata(rd[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .cmd_out(cmd_out), .wdata_out(wdata_out),
    .data_in(data_in), .data_ready_in(data_ready_in), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: ready/busy against the arbitration model, commands and responses against queues.
  always @(negedge clk) begin : monitor
    logic [1:0] er;
    logic       id;
    cmd_t       c;
    rsp_t       r;
    if (!rst_n) begin
      exp_cmd.delete();
      exp_rsp.delete();
      exp_txn.delete();
      last_m   = 1'b1;
      outst    = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      if (outst)                 er = 2'b00;
      else if (rv[0] && rv[1])   er = last_m ? 2'b01 : 2'b10;
      else                       er = rv;
      check("ready", int'({req1_ready, req0_ready}), int'(er));
      check("busy", int'(busy), int'(outst));

      if (cmd_out != 3'd0 || wdata_out != 13'd0) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", int'({cmd_out, wdata_out}), 0);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd", int'(cmd_out), int'(c.cmd));
          check("cmd_wdata", int'(wdata_out), int'(c.data));
          check("cmd_cycle", cyc, c.cyc);
        end
      end
      if (exp_cmd.size() > 0 && exp_cmd[0].cyc < cyc) begin
        c = exp_cmd.pop_front();
        check("cmd_missing", int'(cmd_out), int'(c.cmd));
      end

      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          r = exp_rsp[0];
          check("rsp_id", int'(rsp_id), int'(r.id));
          check("rsp_data", int'(rsp_data), int'(r.data));
          check("rsp_timeout", int'(rsp_timeout), int'(r.to));
          if (!rsp_seen) check("rsp_cycle", cyc, r.cyc);
          rsp_seen = 1'b1;
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            rsp_seen = 1'b0;
            outst    = 1'b0;
            n_rsp++;
          end
        end
      end

      if (er != 2'b00) begin
        id = er[1];
        c.cmd = 3'd1; c.data = {6'd0, rw[id], ra[id]}; c.cyc = cyc + 1;
        exp_cmd.push_back(c);
        c.cmd = rw[id] ? 3'd2 : 3'd3; c.data = rw[id] ? rd[id] : 13'd0; c.cyc = cyc + 2;
        exp_cmd.push_back(c);
        exp_txn.push_back({rw[id], id});
        last_m = id;
        outst  = 1'b1;
      end
    end
  end

  // Harness responder: acknowledges on a chosen WAIT cycle (beyond TO means none in time).
  initial begin : responder
    int          jt [4];
    int          j, k;
    logic [1:0]  t;
    logic [12:0] d;
    rsp_t        r;
    jt = '{2, 4, TO, TO + 1};
    forever begin
      @(negedge clk);
      if (rst_n && auto_resp && (cmd_out == 3'd2 || cmd_out == 3'd3) && exp_txn.size() > 0) begin
        t = exp_txn.pop_front();
        k = cyc;
        j = (n_issued < 4) ? jt[n_issued] : int'($urandom_range(1, TO + 2));
        n_issued++;
        d = 13'($urandom);
        r.id   = t[0];
        r.to   = (j > TO);
        r.data = (t[1] || j > TO) ? 13'd0 : d;
        r.cyc  = k + ((j > TO) ? TO : j) + 1;
        exp_rsp.push_back(r);
        repeat (j) @(posedge clk);
        #1;
        data_ready_in = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        data_ready_in = 1'b0;
        data_in = 13'($urandom);
      end
    end
  end

  task automatic wait_accept0();
    int l = 0;
    bit got = 1'b0;
    while (!got && l < 100) begin
      @(negedge clk);
      got = req0_ready;
      l++;
    end
    check("accept0_seen", int'(got), 1);
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
  endtask

  initial begin : main
    int         rem [2];
    int         lim, bp, n0;
    logic [1:0] acc;
    ra[0] = 6'd0; ra[1] = 6'd0; rd[0] = 13'd0; rd[1] = 13'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", int'(cmd_out), 0);
    check("rst_wdata", int'(wdata_out), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_timeout", int'(rsp_timeout), 0);
    check("rst_busy", int'(busy), 0);

    // Both valid straight out of reset: req0 writes 0x1ABC to 0x05, req1 reads 0x3F.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = 2'b11; rw = 2'b01;
    ra[0] = 6'h05; rd[0] = 13'h1ABC;
    ra[1] = 6'h3F; rd[1] = 13'($urandom);
    rsp_ready = 1'b1;
    rem = '{NPER, NPER};
    lim = 0;
    bp = 0;
    while (n_rsp < 2 * NPER && lim < 20000) begin
      @(negedge clk);
      acc = {req1_ready & rv[1], req0_ready & rv[0]};
      @(posedge clk);
      #1;
      lim++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          rv[i] = 1'b0;
          rem[i]--;
        end
        if (!rv[i]) begin
          rw[i] = 1'($urandom_range(0, 1));
          ra[i] = 6'($urandom);
          rd[i] = 13'($urandom);
          if (rem[i] > 0 && $urandom_range(0, 3) != 0) rv[i] = 1'b1;
        end
      end
      if (bp > 0) begin
        bp--;
        rsp_ready = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        bp = 9;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    check("random_phase_done", n_rsp, 2 * NPER);

    // Reset in the middle of a read's WAIT phase, then a fresh read.
    rv = 2'b00;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    auto_resp = 1'b0;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'h2A;
    wait_accept0();
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_resp = 1'b1;
    @(negedge clk);
    check("abort_cmd", int'(cmd_out), 0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("abort_busy", int'(busy), 0);
    n0 = n_rsp;
    @(posedge clk);
    #1;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'h11;
    wait_accept0();
    lim = 0;
    while (n_rsp == n0 && lim < 200) begin
      @(posedge clk);
      lim++;
    end
    check("post_reset_rsp", n_rsp, n0 + 1);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
